// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver state type and oversampling constants
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
  localparam int OVERSAMPLE = 16;
  localparam logic [3:0] SAMPLE_LO = 4'd7;
  localparam logic [3:0] SAMPLE_MID = 4'd8;
  localparam logic [3:0] SAMPLE_HI = 4'd9;
  localparam logic [3:0] BIT_END = 4'd15;
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: flop-chain synchroniser for the asynchronous rx line, idles high
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [SYNC_STAGES-1:0] ff;
  // shift the raw line through the chain; reset to the idle level so no false start
  always_ff @(posedge clk)
    ff <= rst ? '1 : {ff[SYNC_STAGES-2:0], d};
  assign q = ff[SYNC_STAGES-1];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled 8N1 receiver with majority vote and valid/ready holding register
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_16x,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       overrun_err
);
  rx_state_t state, state_n;
  logic [3:0] tick_cnt, cnt_n;
  logic [2:0] bit_idx, idx_n;
  logic [7:0] shreg, sh_n, data_n;
  logic [1:0] votes, vote_n, vsum;
  logic valid_n, ferr_n, oerr_n, rx_s, maj, win, last;
  uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk),
    .rst(rst),
    .d(rx),
    .q(rx_s)
  );
  assign vsum = votes + {1'b0, rx_s};
  assign maj = vsum[1];
  assign win = tick_cnt >= SAMPLE_LO && tick_cnt <= SAMPLE_HI;
  assign last = bit_idx == 3'(DATA_BITS - 1);
  assign rx_busy = state != IDLE;
  // next-state, vote/shift datapath and holding-register update
  always_comb begin
    state_n = state;
    cnt_n = tick_cnt;
    idx_n = bit_idx;
    sh_n = shreg;
    vote_n = votes;
    data_n = rx_data;
    valid_n = rx_valid & ~rx_ready;
    ferr_n = 1'b0;
    oerr_n = 1'b0;
    if (tick_16x) begin
      cnt_n = tick_cnt + 4'd1;
      vote_n = win ? vsum : votes;
      unique case (state)
        IDLE: begin
          vote_n = '0;
          cnt_n = rx_s ? 4'd0 : 4'd1;
          state_n = rx_s ? IDLE : START;
        end
        START: begin
          if (tick_cnt == SAMPLE_HI && maj) begin
            state_n = IDLE;
            cnt_n = '0;
          end else if (tick_cnt == BIT_END) begin
            state_n = DATA;
            idx_n = '0;
            vote_n = '0;
          end
        end
        DATA: begin
          if (tick_cnt == SAMPLE_HI) sh_n = {maj, shreg[7:1]};
          if (tick_cnt == BIT_END) begin
            vote_n = '0;
            idx_n = bit_idx + 3'd1;
            state_n = last ? STOP : DATA;
          end
        end
        STOP: begin
          if (tick_cnt == SAMPLE_HI) begin
            state_n = IDLE;
            cnt_n = '0;
            if (!maj) ferr_n = 1'b1;
            else if (!rx_valid || rx_ready) begin
              data_n = shreg >> (8 - DATA_BITS);
              valid_n = 1'b1;
            end else oerr_n = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end
  // state and output registers; reset aborts any frame in flight
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      tick_cnt <= '0;
      bit_idx <= '0;
      shreg <= '0;
      votes <= '0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      state <= state_n;
      tick_cnt <= cnt_n;
      bit_idx <= idx_n;
      shreg <= sh_n;
      votes <= vote_n;
      rx_data <= data_n;
      rx_valid <= valid_n;
      frame_err <= ferr_n;
      overrun_err <= oerr_n;
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized self-checking bench for uart_rx against a frame-level model
module tb_uart_rx;
  logic clk = 1'b0, rst = 1'b1, tick = 1'b0, rx = 1'b1, rx7 = 1'b1, rdy = 1'b1, rdy7 = 1'b1;
  logic [7:0] d, d7;
  logic v, v7, busy, busy7, fe, fe7, oe, oe7;
  int n_chk = 0, n_fail = 0, tick_per = 400, acc = 0;
  int cyc = 0, edge_cyc = 0, rise_cyc = 0, busy_len = 0, last_busy = 0;
  int fe_n = 0, oe_n = 0, fe7_n = 0, oe7_n = 0;
  logic [7:0] got_q[$], got7_q[$], exp_q[$];
  logic [7:0] b;

  uart_rx u0 (
    .clk(clk), .rst(rst), .tick_16x(tick), .rx(rx), .rx_data(d), .rx_valid(v),
    .rx_ready(rdy), .rx_busy(busy), .frame_err(fe), .overrun_err(oe)
  );
  uart_rx #(.DATA_BITS(7)) u7 (
    .clk(clk), .rst(rst), .tick_16x(tick), .rx(rx7), .rx_data(d7), .rx_valid(v7),
    .rx_ready(rdy7), .rx_busy(busy7), .frame_err(fe7), .overrun_err(oe7)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(negedge clk);
    acc = acc + 100;
    if (acc >= tick_per) begin
      tick = 1'b1;
      acc = acc - tick_per;
    end else tick = 1'b0;
  end

  initial forever begin
    @(negedge clk);
    #3;
    if (v && rdy) got_q.push_back(d);
    if (v7 && rdy7) got7_q.push_back(d7);
    fe_n += int'(fe);
    oe_n += int'(oe);
    fe7_n += int'(fe7);
    oe7_n += int'(oe7);
    if (busy) begin
      if (busy_len == 0) rise_cyc = cyc;
      busy_len++;
    end else if (busy_len != 0) begin
      last_busy = busy_len;
      busy_len = 0;
    end
    cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr();
    got_q.delete();
    got7_q.delete();
    exp_q.delete();
    fe_n = 0; oe_n = 0; fe7_n = 0; oe7_n = 0;
  endtask

  task automatic send(input logic [7:0] byt, input int nb, input logic stop, input int w, input bit seven);
    logic bv;
    for (int i = 0; i < nb + 2; i++) begin
      bv = (i == 0) ? 1'b0 : (i <= nb) ? byt[i-1] : stop;
      if (seven) rx7 = bv;
      else begin
        rx = bv;
        if (i == 0) edge_cyc = cyc;
      end
      repeat (w) @(negedge clk);
    end
    rx = 1'b1;
    rx7 = 1'b1;
  endtask

  initial begin
    idle(5);
    rst = 1'b0;
    idle(2);
    chk("reset rx_data", d, 0);
    chk("reset rx_valid", v, 0);
    chk("reset rx_busy", busy, 0);
    chk("reset frame_err", fe, 0);
    chk("reset overrun_err", oe, 0);

    clr();
    send(8'hA5, 8, 1'b1, 64, 0);
    idle(100);
    chk("a5 count", got_q.size(), 1);
    chk("a5 data", got_q[0], 8'hA5);
    chk("a5 frame_err", fe_n, 0);
    chk("a5 overrun", oe_n, 0);
    chk("a5 busy length", last_busy, 612);
    chk("a5 busy rise window", (rise_cyc - edge_cyc >= 3) && (rise_cyc - edge_cyc <= 6), 1);
    clr();
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      send(b, 8, 1'b1, 64, 0);
    end
    idle(100);
    chk("b2b count", got_q.size(), 4);
    for (int i = 0; i < 4; i++) chk("b2b data", got_q[i], exp_q[i]);
    chk("b2b errors", fe_n + oe_n, 0);

    clr();
    rx = 1'b0;
    idle(12);
    rx = 1'b1;
    idle(100);
    chk("glitch valid", got_q.size(), 0);
    chk("glitch frame_err", fe_n, 0);
    chk("glitch busy length", last_busy, 36);
    chk("glitch idle", busy, 0);

    clr();
    send(8'h3C, 8, 1'b0, 64, 0);
    idle(200);
    chk("badstop frame_err", fe_n, 1);
    chk("badstop valid", v, 0);
    chk("badstop delivered", got_q.size(), 0);
    send(8'h55, 8, 1'b1, 64, 0);
    idle(100);
    chk("after badstop count", got_q.size(), 1);
    chk("after badstop data", got_q[0], 8'h55);
    chk("after badstop frame_err", fe_n, 1);

    clr();
    rdy = 1'b0;
    send(8'h11, 8, 1'b1, 64, 0);
    send(8'h22, 8, 1'b1, 64, 0);
    idle(100);
    chk("overrun held data", d, 8'h11);
    chk("overrun held valid", v, 1);
    chk("overrun pulse", oe_n, 1);
    chk("overrun frame_err", fe_n, 0);
    rdy = 1'b1;
    @(posedge clk);
    #1;
    chk("accept drops valid", v, 0);
    @(negedge clk);
    chk("accepted byte", got_q.size() == 1 && got_q[0] == 8'h11, 1);

    clr();
    fork
      send(8'hF0, 8, 1'b1, 64, 0);
      begin
        idle(5 * 64 + 32);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
      end
    join
    chk("abort busy", busy, 0);
    idle(100);
    send(8'h81, 8, 1'b1, 64, 0);
    idle(100);
    chk("abort count", got_q.size(), 1);
    chk("abort data", got_q[0], 8'h81);
    chk("abort errors", fe_n + oe_n, 0);

    clr();
    tick_per = 412;
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom_range(0, 127));
      exp_q.push_back(b);
      send(b, 7, 1'b1, 64, 1);
    end
    idle(200);
    chk("slow7 count", got7_q.size(), 16);
    for (int i = 0; i < 16; i++) chk("slow7 data", got7_q[i], exp_q[i]);
    chk("slow7 frame_err", fe7_n, 0);
    chk("slow7 overrun", oe7_n, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 16x-oversampled UART receiver. It is the receive-side counterpart of the existing transmitter and shares the same tick_16x baud strobe.
- Frame format: 8N1, LSB first, idle high.
- It synchronises the asynchronous rx line and majority-votes each bit at its centre.
- It presents received bytes on a valid/ready holding register, with framing-error and overrun flags. It feeds the UART-to-SPI bridge datapath.

Parameters:
- DATA_BITS, 8, number of data bits per frame (legal range 5..8); rx_data is always 8 bits wide, with unused MSBs zero.
- SYNC_STAGES, 2, flip-flop depth of the rx input synchroniser (minimum 2).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- tick_16x  in  1  one-clk-wide strobe at 16x the baud rate.
- rx  in  1  asynchronous serial input, idle high.
- rx_data  out  8  received byte; held stable while rx_valid=1.
- rx_valid  out  1  byte available; held until accepted.
- rx_ready  in  1  consumer accepts the byte when rx_valid & rx_ready.
- rx_busy  out  1  high while a frame is in progress (any state other than IDLE).
- frame_err  out  1  one-clk pulse when the stop bit samples as 0.
- overrun_err  out  1  one-clk pulse when a good frame completes while the holding register is still full.

Behaviour:
- Reset values:
  - rx_data=0, rx_valid=0, rx_busy=0, frame_err=0, overrun_err=0.
  - All synchroniser flops = 1; state=IDLE; tick_cnt=0, bit_idx=0, shift register=0.
- Reset asserted mid-frame aborts the frame immediately. Nothing is delivered and no error is flagged.
- Synchroniser: rx passes through SYNC_STAGES flops clocked every clk. All decisions use rx_s, the last stage.
- tick_cnt is 4 bits, advances only on tick_16x, and wraps 15->0. Votes are taken at tick_cnt 7, 8 and 9; a bit's value is the majority of the 3 samples.
- States:
  - IDLE: on a tick_16x where rx_s=0, go to START with tick_cnt=1, and clear the vote accumulator.
  - START: collect votes at counts 7–9.
    - At the count-9 tick, if the majority is 1 (false start / glitch), return to IDLE with no flags.
    - Otherwise remain in START until the count-15 tick, then go to DATA with bit_idx=0, tick_cnt=0.
  - DATA: vote at counts 7–9 and shift the majority into the MSB of the shift register (LSB-first reception).
    - At the count-15 tick, increment bit_idx.
    - After bit DATA_BITS-1 completes, go to STOP.
  - STOP: vote at counts 7–9. At the count-9 tick, decide the frame (below) and go to IDLE.
    - Early exit keeps 6 ticks of margin for the next start edge.
    - A start detected in IDLE on the very next tick is legal.
- Good stop (majority 1):
  - If rx_valid=0, or rx_ready=1 in the same cycle: load rx_data (right-aligned to DATA_BITS, upper bits zero) and set rx_valid=1.
  - Otherwise: keep the old rx_data and rx_valid, drop the new byte, and pulse overrun_err.
- Bad stop (majority 0): pulse frame_err. rx_data and rx_valid are unchanged and no byte is delivered.
- Handshake:
  - rx_valid clears in the cycle after rx_valid & rx_ready.
  - Simultaneous accept and new delivery: the new byte loads, rx_valid stays 1, and there is no overrun.
- Latency: rx_valid rises 1 clk after the tick_16x at stop count 9, plus synchroniser delay (SYNC_STAGES clks) relative to the rx pin.
- Continuous back-to-back frames at the nominal baud must be received without loss. Baud mismatch up to ±3% must be tolerated.
- tick_16x arriving while rst=1 is ignored.

Decomposition:
- Shared package uart_pkg holds:
  - rx state enum (IDLE, START, DATA, STOP);
  - constants OVERSAMPLE=16, SAMPLE_LO=7, SAMPLE_MID=8, SAMPLE_HI=9, BIT_END=15.
- One natural sub-module: uart_rx_sync, a parameterised SYNC_STAGES flop chain with reset-to-1. The voter and FSM stay in uart_rx.

Test Plan:
- Bench tick every 4 clks (64 clks per bit). Send 0xA5 8N1, rx_ready=1:
  - one rx_valid pulse;
  - rx_data=0xA5;
  - frame_err=0, overrun_err=0;
  - rx_busy high from the start edge + SYNC_STAGES to stop count 9.
- Low glitch on rx lasting 3 ticks while idle, then high: no rx_valid, no frame_err, and the FSM returns to IDLE by count 9.
- Send 0x3C with the stop bit forced to 0: frame_err pulses once; rx_valid stays 0; the next clean frame 0x55 is received correctly.
- rx_ready=0, send 0x11 then 0x22 back-to-back:
  - rx_data=0x11 and rx_valid held;
  - overrun_err pulses at the end of the second frame.
  - Then raise rx_ready: rx_valid drops next cycle.
- Assert rst for 1 clk during data bit 4 of 0xF0, then send 0x81: no output for 0xF0; 0x81 received; no error flags.
- DATA_BITS=7, tick period stretched 3% slow, 16 random back-to-back bytes: all received, with bit 7 = 0 and no errors.
